rom_arbiter: RTL and testbench

- Round-robin arbiter that shares one synchronous single-port rom (registered data_out, 1-cycle read latency) among NUM_REQ requesters.
- Accepts per-requester read requests, drives the rom address, and returns the read data tagged with the requester that issued it.
- Sits between client engines and the rom instance. Sustains one read per clock.

---
 rtl/rom_arb_pkg.sv | 38 +++
 rtl/rom_arbiter_rr_pick.sv | 30 +++
 rtl/rom_arbiter.sv | 108 ++++++++++
 tb/tb_rom_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared constants and helpers for the rom_arbiter: stats counter width,
// one-hot to binary conversion and the wrapping round-robin search.
package rom_arb_pkg;

  localparam int STAT_W  = 16;
  localparam int MAX_REQ = 8;

  function automatic logic [2:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = idx | i[2:0];
    end
    return idx;
  endfunction

  // First set bit of req at or above ptr, wrapping at n-1 back to 0.
  function automatic logic [MAX_REQ-1:0] rr_search(input logic [MAX_REQ-1:0] req,
                                                   input int ptr, input int n);
    logic [MAX_REQ-1:0] gnt;
    logic               found;
    int                 idx;
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (i < n) begin
        idx = ptr + i;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx[2:0]]) begin
          gnt[idx[2:0]] = 1'b1;
          found         = 1'b1;
        end
      end
    end
    return gnt;
  endfunction

endpackage

// File: rtl/rom_arbiter_rr_pick.sv
// Purely combinational round-robin selector: one-hot grant plus its binary index.
import rom_arb_pkg::*;

module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx
);

  logic [MAX_REQ-1:0] req_ext;
  logic [MAX_REQ-1:0] gnt_ext;
  logic [2:0]         idx_ext;
  logic               unused_bits;

  always_comb begin
    req_ext              = '0;
    req_ext[NUM_REQ-1:0] = req;
    gnt_ext              = rr_search(req_ext, int'(ptr), NUM_REQ);
    idx_ext              = onehot_to_idx(gnt_ext);
  end

  assign gnt         = gnt_ext[NUM_REQ-1:0];
  assign gnt_idx     = idx_ext[IDX_W-1:0];
  assign unused_bits = ^{gnt_ext, idx_ext};

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one registered-output rom among NUM_REQ clients.
// Optional per-requester grant counters when ROM_ARB_STATS_EN is defined.
import rom_arb_pkg::*;

module rom_arbiter #(
  parameter  int NUM_REQ   = 4,
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 16,
  localparam int LOG_DEPTH = $clog2(DEPTH),
  localparam int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*LOG_DEPTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]           gnt,
  output logic [LOG_DEPTH-1:0]         address,
  input  logic [WIDTH-1:0]             data_in,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [IDX_W-1:0]             rsp_id,
`ifdef ROM_ARB_STATS_EN
  input  logic                         stat_clear,
  output logic [NUM_REQ*STAT_W-1:0]    stat_grants,
`endif
  output logic [WIDTH-1:0]             rsp_data
);

  logic [NUM_REQ-1:0]   pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     next_ptr;
  logic [LOG_DEPTH-1:0] addr_sel;
  logic                 xfer;
  logic                 vld_p1, vld_p2;
  logic [IDX_W-1:0]     id_p1, id_p2;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (req),
    .ptr     (ptr),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

  // Grants are suppressed during reset so no transfer is seen while it is held.
  assign gnt  = reset ? '0 : pick_gnt;
  assign xfer = |gnt;

  always_comb begin
    addr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) addr_sel = req_addr[i*LOG_DEPTH +: LOG_DEPTH];
    end
  end

  assign next_ptr = (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr       <= '0;
      address   <= '0;
      vld_p1    <= 1'b0;
      id_p1     <= '0;
      vld_p2    <= 1'b0;
      id_p2     <= '0;
      rsp_valid <= '0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      // Stage 0 -> 1: transfer edge, rom address registered
      vld_p1 <= xfer;
      if (xfer) begin
        ptr     <= next_ptr;
        address <= addr_sel;
        id_p1   <= pick_idx;
      end
      // Stage 1 -> 2: rom samples address, data_in valid afterwards
      vld_p2 <= vld_p1;
      id_p2  <= id_p1;
      // Stage 2 -> response: capture rom data and tag it
      rsp_valid <= vld_p2 ? (NUM_REQ'(1) << id_p2) : '0;
      if (vld_p2) begin
        rsp_id   <= id_p2;
        rsp_data <= data_in;
      end
    end
  end

`ifdef ROM_ARB_STATS_EN
  logic [STAT_W-1:0] grant_cnt [NUM_REQ];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
    end else if (stat_clear) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[i] && (grant_cnt[i] != '1)) grant_cnt[i] <= grant_cnt[i] + 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_grants[g*STAT_W +: STAT_W] = grant_cnt[g];
  end
`endif

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a behavioural rom; table-driven grant/response
// vectors plus hand sequences for the sweep, mid-flight reset and optional stats.
module tb_rom_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] req_addr;
  logic [3:0]  gnt;
  logic [3:0]  address;
  logic [7:0]  data_in;
  logic [3:0]  rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
`ifdef ROM_ARB_STATS_EN
  logic        stat_clear;
  logic [63:0] stat_grants;
`endif

  int checks;
  int errors;

  rom_arbiter #(.NUM_REQ(4), .WIDTH(8), .DEPTH(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_addr    (req_addr),
    .gnt         (gnt),
    .address     (address),
    .data_in     (data_in),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
`ifdef ROM_ARB_STATS_EN
    .stat_clear  (stat_clear),
    .stat_grants (stat_grants),
`endif
    .rsp_data    (rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom_val(input logic [3:0] a);
    return {a, ~a} ^ 8'h3C;
  endfunction

  // Synchronous rom with registered output
  always_ff @(posedge clk) data_in <= rom_val(address);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [15:0] addrs;
    logic [3:0]  gnt;
    logic [3:0]  address;
    logic [3:0]  rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_data;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] r, input logic [15:0] a, input logic [3:0] g,
                              input logic [3:0] ad, input logic [3:0] rv, input logic [1:0] ri,
                              input logic [7:0] rd);
    vec_t v;
    v.req = r; v.addrs = a; v.gnt = g; v.address = ad;
    v.rsp_valid = rv; v.rsp_id = ri; v.rsp_data = rd;
    return v;
  endfunction

  vec_t tbl[23];

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b1;
    req        = 4'b1111;
    req_addr   = 16'h4321;
`ifdef ROM_ARB_STATS_EN
    stat_clear = 1'b0;
`endif

    // full contention, idle drain, pointer wrap, single request, wrapped search
    tbl[0]  = mk(4'b1111, 16'h4321, 4'b0001, 4'd1, 4'b0000, 2'd0, 8'h00);
    tbl[1]  = mk(4'b1111, 16'h4321, 4'b0010, 4'd2, 4'b0000, 2'd0, 8'h00);
    tbl[2]  = mk(4'b1111, 16'h4321, 4'b0100, 4'd3, 4'b0001, 2'd0, rom_val(4'd1));
    tbl[3]  = mk(4'b1111, 16'h4321, 4'b1000, 4'd4, 4'b0010, 2'd1, rom_val(4'd2));
    tbl[4]  = mk(4'b1111, 16'h4321, 4'b0001, 4'd1, 4'b0100, 2'd2, rom_val(4'd3));
    tbl[5]  = mk(4'b1111, 16'h4321, 4'b0010, 4'd2, 4'b1000, 2'd3, rom_val(4'd4));
    tbl[6]  = mk(4'b1111, 16'h4321, 4'b0100, 4'd3, 4'b0001, 2'd0, rom_val(4'd1));
    tbl[7]  = mk(4'b1111, 16'h4321, 4'b1000, 4'd4, 4'b0010, 2'd1, rom_val(4'd2));
    tbl[8]  = mk(4'b0000, 16'h4321, 4'b0000, 4'd4, 4'b0100, 2'd2, rom_val(4'd3));
    tbl[9]  = mk(4'b0000, 16'h4321, 4'b0000, 4'd4, 4'b1000, 2'd3, rom_val(4'd4));
    tbl[10] = mk(4'b1000, 16'h9007, 4'b1000, 4'd9, 4'b0000, 2'd0, rom_val(4'd4));
    tbl[11] = mk(4'b1001, 16'h9007, 4'b0001, 4'd7, 4'b0000, 2'd0, rom_val(4'd4));
    tbl[12] = mk(4'b1001, 16'h9007, 4'b1000, 4'd9, 4'b1000, 2'd3, rom_val(4'd9));
    tbl[13] = mk(4'b0000, 16'h9007, 4'b0000, 4'd9, 4'b0001, 2'd0, rom_val(4'd7));
    tbl[14] = mk(4'b0000, 16'h9007, 4'b0000, 4'd9, 4'b1000, 2'd3, rom_val(4'd9));
    tbl[15] = mk(4'b0001, 16'h0005, 4'b0001, 4'd5, 4'b0000, 2'd0, rom_val(4'd9));
    tbl[16] = mk(4'b0000, 16'h0005, 4'b0000, 4'd5, 4'b0000, 2'd0, rom_val(4'd9));
    tbl[17] = mk(4'b0000, 16'h0005, 4'b0000, 4'd5, 4'b0001, 2'd0, rom_val(4'd5));
    tbl[18] = mk(4'b0101, 16'h0603, 4'b0100, 4'd6, 4'b0000, 2'd0, rom_val(4'd5));
    tbl[19] = mk(4'b0101, 16'h0603, 4'b0001, 4'd3, 4'b0000, 2'd0, rom_val(4'd5));
    tbl[20] = mk(4'b0000, 16'h0603, 4'b0000, 4'd3, 4'b0100, 2'd2, rom_val(4'd6));
    tbl[21] = mk(4'b0000, 16'h0603, 4'b0000, 4'd3, 4'b0001, 2'd0, rom_val(4'd3));
    tbl[22] = mk(4'b0000, 16'h0603, 4'b0000, 4'd3, 4'b0000, 2'd0, rom_val(4'd3));

    // reset state, with requests pending
    repeat (2) @(posedge clk);
    #1;
    check("reset_gnt", gnt, 4'b0000);
    check("reset_address", address, 4'd0);
    check("reset_rsp_valid", rsp_valid, 4'b0000);
    check("reset_rsp_id", rsp_id, 2'd0);
    check("reset_rsp_data", rsp_data, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b0000;

    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      req      = tbl[i].req;
      req_addr = tbl[i].addrs;
      #1;
      check($sformatf("vec%0d_gnt", i), gnt, tbl[i].gnt);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_address", i), address, tbl[i].address);
      check($sformatf("vec%0d_rsp_valid", i), rsp_valid, tbl[i].rsp_valid);
      if (tbl[i].rsp_valid != 4'b0000)
        check($sformatf("vec%0d_rsp_id", i), rsp_id, tbl[i].rsp_id);
      check($sformatf("vec%0d_rsp_data", i), rsp_data, tbl[i].rsp_data);
    end

    // back-to-back sweep by requester 2 over every rom word
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      req      = (i < 16) ? 4'b0100 : 4'b0000;
      req_addr = (i < 16) ? (16'(i) << 8) : 16'h0000;
      #1;
      if (i < 16) check($sformatf("sweep%0d_gnt", i), gnt, 4'b0100);
      @(posedge clk);
      #1;
      check($sformatf("sweep%0d_rsp_valid", i), rsp_valid, (i >= 2) ? 4'b0100 : 4'b0000);
      if (i >= 2) begin
        check($sformatf("sweep%0d_rsp_id", i), rsp_id, 2'd2);
        check($sformatf("sweep%0d_rsp_data", i), rsp_data, rom_val(4'(i - 2)));
      end
    end

    // reset one cycle after a transfer drops the in-flight read
    @(negedge clk);
    req      = 4'b0001;
    req_addr = 16'h000A;
    #1;
    check("midrst_gnt_before", gnt, 4'b0001);
    @(posedge clk);
    #1;
    check("midrst_address_before", address, 4'd10);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_gnt", gnt, 4'b0000);
    check("midrst_address", address, 4'd0);
    check("midrst_rsp_valid", rsp_valid, 4'b0000);
    check("midrst_rsp_id", rsp_id, 2'd0);
    check("midrst_rsp_data", rsp_data, 8'h00);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("midrst_hold%0d_rsp_valid", i), rsp_valid, 4'b0000);
    end
    @(negedge clk);
    reset    = 1'b0;
    req      = 4'b1010;
    req_addr = 16'hC0B0;
    #1;
    check("postrst_gnt", gnt, 4'b0010);
    @(posedge clk);
    #1;
    check("postrst_address", address, 4'd11);
    check("postrst_rsp_valid0", rsp_valid, 4'b0000);
    @(negedge clk);
    req = 4'b0000;
    @(posedge clk);
    #1;
    check("postrst_rsp_valid1", rsp_valid, 4'b0000);
    @(posedge clk);
    #1;
    check("postrst_rsp_valid2", rsp_valid, 4'b0010);
    check("postrst_rsp_id", rsp_id, 2'd1);
    check("postrst_rsp_data", rsp_data, rom_val(4'd11));
    @(posedge clk);
    #1;
    check("postrst_rsp_valid3", rsp_valid, 4'b0000);

`ifdef ROM_ARB_STATS_EN
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("stats_reset", stat_grants, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    req   = 4'b0010;
    repeat (5) @(posedge clk);
    @(negedge clk);
    req = 4'b0000;
    check("stats_slice0", stat_grants[15:0], 16'd0);
    check("stats_slice1", stat_grants[31:16], 16'd5);
    check("stats_slice2", stat_grants[47:32], 16'd0);
    check("stats_slice3", stat_grants[63:48], 16'd0);
    req        = 4'b0010;
    stat_clear = 1'b1;
    @(posedge clk);
    #1;
    check("stats_clear_wins", stat_grants, 64'h0);
    @(negedge clk);
    stat_clear = 1'b0;
    req        = 4'b0001;
    repeat (65537) @(posedge clk);
    @(negedge clk);
    req = 4'b0000;
    check("stats_saturate", stat_grants[15:0], 16'hFFFF);
    check("stats_saturate_other", stat_grants[63:16], 48'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
